// File: rtl/next_line_prefetcher.sv
// next_line_prefetcher: fetches the line after a demand miss into a single-entry buffer for the cache
module next_line_prefetcher #(
  parameter int s_offset = 5,
  parameter int s_line   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prefetch_start,
  input  logic [31:0]       cacheline_address,
  input  logic              cache_way,
  output logic [s_line-1:0] prefetch_rdata,
  output logic              prefetch_ready,
  output logic [31:0]       pf_cline_address,
  output logic              pf_cache_way,
  output logic              pf_pmem_read,
  output logic [31:0]       pf_pmem_address,
  input  logic [s_line-1:0] pf_pmem_rdata,
  input  logic              pf_pmem_resp
);
  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << s_offset) - 32'd1);
  state_t            state_q, state_d;
  logic [31:0]       tgt_q, tgt_d, pend_tgt_q, pend_tgt_d;
  logic              way_q, way_d, pend_q, pend_d, pend_way_q, pend_way_d;
  logic [s_line-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d, pfway_q, pfway_d, read_q, read_d;
  logic [31:0]       cline_q, cline_d, addr_q, addr_d;
  logic [31:0]       tgt;
  logic              start_ok, launch, resp_ok, fill, gap, queue;
  // a line index of all ones has no successor, so such a start carries no target
  assign tgt      = (cacheline_address & LINE_MASK) + (32'd1 << s_offset);
  assign start_ok = prefetch_start & ~&cacheline_address[31:s_offset];
  assign launch   = start_ok & (state_q == IDLE | (state_q == READY & tgt != cline_q));
  assign resp_ok  = state_q == FETCH & read_q & pf_pmem_resp;
  assign fill     = resp_ok & ~pend_q & ~start_ok;
  assign gap      = state_q == FETCH & ~read_q;
  assign queue    = state_q == FETCH & read_q & start_ok;
  // state and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      way_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      pend_way_q <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      cline_q    <= '0;
      pfway_q    <= 1'b0;
      read_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      way_q      <= way_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      pend_way_q <= pend_way_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      cline_q    <= cline_d;
      pfway_q    <= pfway_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
    end
  end
  // next state: a response only retires to READY when no newer start is waiting
  always_comb begin
    state_d = state_q == IDLE  ? (start_ok ? FETCH : IDLE) :
              state_q == FETCH ? (fill ? READY : FETCH) :
              state_q == READY ? (launch ? FETCH : READY) : IDLE;
  end
  // request, pending slot and buffer; the read-low gap cycle reissues the newest pending target
  always_comb begin
    tgt_d      = launch ? tgt : gap ? (start_ok ? tgt : pend_tgt_q) : tgt_q;
    way_d      = launch ? cache_way : gap ? (start_ok ? cache_way : pend_way_q) : way_q;
    pend_d     = gap ? 1'b0 : queue ? 1'b1 : pend_q;
    pend_tgt_d = queue ? tgt : pend_tgt_q;
    pend_way_d = queue ? cache_way : pend_way_q;
    read_d     = launch | gap | (read_q & ~resp_ok);
    addr_d     = (launch | gap) ? tgt_d : addr_q;
    rdata_d    = fill ? pf_pmem_rdata : rdata_q;
    ready_d    = fill | (ready_q & ~launch);
    cline_d    = fill ? tgt_q : cline_q;
    pfway_d    = fill ? way_q : pfway_q;
  end
  assign prefetch_rdata   = rdata_q;
  assign prefetch_ready   = ready_q;
  assign pf_cline_address = cline_q;
  assign pf_cache_way     = pfway_q;
  assign pf_pmem_read     = read_q;
  assign pf_pmem_address  = addr_q;
endmodule

// File: tb/tb_next_line_prefetcher.sv
// tb_next_line_prefetcher: directed checks of the next-line prefetcher
module tb_next_line_prefetcher;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         prefetch_start = 1'b0;
  logic [31:0]  cacheline_address = '0;
  logic         cache_way = 1'b0;
  logic [255:0] prefetch_rdata;
  logic         prefetch_ready;
  logic [31:0]  pf_cline_address;
  logic         pf_cache_way;
  logic         pf_pmem_read;
  logic [31:0]  pf_pmem_address;
  logic [255:0] pf_pmem_rdata = '0;
  logic         pf_pmem_resp = 1'b0;
  int           errs = 0;
  int           checks = 0;
  localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
  localparam logic [255:0] D2 = {8{32'h5A5A_0002}};
  localparam logic [255:0] D3 = {8{32'hDEAD_0003}};
  localparam logic [255:0] D4 = {8{32'hBEEF_0004}};
  localparam logic [255:0] D5 = {8{32'hC0DE_0005}};
  localparam logic [255:0] D6 = {8{32'hF00D_0006}};
  next_line_prefetcher dut (
    .clk(clk), .rst(rst), .prefetch_start(prefetch_start),
    .cacheline_address(cacheline_address), .cache_way(cache_way),
    .prefetch_rdata(prefetch_rdata), .prefetch_ready(prefetch_ready),
    .pf_cline_address(pf_cline_address), .pf_cache_way(pf_cache_way),
    .pf_pmem_read(pf_pmem_read), .pf_pmem_address(pf_pmem_address),
    .pf_pmem_rdata(pf_pmem_rdata), .pf_pmem_resp(pf_pmem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [31:0] a, input logic w);
    @(negedge clk);
    prefetch_start = 1'b1;
    cacheline_address = a;
    cache_way = w;
    @(negedge clk);
    prefetch_start = 1'b0;
  endtask
  task automatic resp(input logic [255:0] d);
    @(negedge clk);
    pf_pmem_resp = 1'b1;
    pf_pmem_rdata = d;
    @(negedge clk);
    pf_pmem_resp = 1'b0;
  endtask
  task automatic zero_chk(input string tag);
    chk({tag, "_read"}, pf_pmem_read, 0);
    chk({tag, "_addr"}, pf_pmem_address, 0);
    chk({tag, "_ready"}, prefetch_ready, 0);
    chk({tag, "_rdata"}, prefetch_rdata, 0);
    chk({tag, "_cline"}, pf_cline_address, 0);
    chk({tag, "_way"}, pf_cache_way, 0);
  endtask
  initial begin
    logic seen;
    #1 rst = 1'b0;
    #2 zero_chk("reset");
    @(negedge clk) rst = 1'b1;
    start(32'h0000_1044, 1'b1);
    chk("s1_read", pf_pmem_read, 1);
    chk("s1_addr", pf_pmem_address, 32'h0000_1060);
    chk("s1_ready0", prefetch_ready, 0);
    repeat (3) @(negedge clk);
    chk("s1_hold_read", pf_pmem_read, 1);
    chk("s1_hold_addr", pf_pmem_address, 32'h0000_1060);
    resp(D1);
    chk("s1_ready", prefetch_ready, 1);
    chk("s1_rdata", prefetch_rdata, D1);
    chk("s1_cline", pf_cline_address, 32'h0000_1060);
    chk("s1_way", pf_cache_way, 1);
    chk("s1_read_off", pf_pmem_read, 0);
    start(32'h0000_1040, 1'b0);
    seen = pf_pmem_read;
    repeat (10) begin
      @(negedge clk);
      seen |= pf_pmem_read;
    end
    chk("s2_no_read", seen, 0);
    chk("s2_ready", prefetch_ready, 1);
    chk("s2_rdata", prefetch_rdata, D1);
    chk("s2_way", pf_cache_way, 1);
    start(32'h0000_2000, 1'b0);
    chk("s3_ready0", prefetch_ready, 0);
    chk("s3_read", pf_pmem_read, 1);
    chk("s3_addr", pf_pmem_address, 32'h0000_2020);
    repeat (2) @(negedge clk);
    resp(D2);
    chk("s3_ready", prefetch_ready, 1);
    chk("s3_rdata", prefetch_rdata, D2);
    chk("s3_cline", pf_cline_address, 32'h0000_2020);
    chk("s3_way", pf_cache_way, 0);
    start(32'hFFFF_FFE4, 1'b1);
    chk("s5r_ready", prefetch_ready, 1);
    chk("s5r_read", pf_pmem_read, 0);
    chk("s5r_cline", pf_cline_address, 32'h0000_2020);
    chk("s5r_rdata", prefetch_rdata, D2);
    start(32'h0000_0100, 1'b1);
    chk("s4_read", pf_pmem_read, 1);
    chk("s4_addr", pf_pmem_address, 32'h0000_0120);
    start(32'h0000_0400, 1'b0);
    chk("s4_noabort", pf_pmem_address, 32'h0000_0120);
    resp(D3);
    chk("s4_discard_ready", prefetch_ready, 0);
    chk("s4_gap_read", pf_pmem_read, 0);
    @(negedge clk);
    chk("s4_reissue_read", pf_pmem_read, 1);
    chk("s4_reissue_addr", pf_pmem_address, 32'h0000_0420);
    resp(D4);
    chk("s4_ready", prefetch_ready, 1);
    chk("s4_rdata", prefetch_rdata, D4);
    chk("s4_cline", pf_cline_address, 32'h0000_0420);
    chk("s4_way", pf_cache_way, 0);
    start(32'h0000_0800, 1'b1);
    chk("sc_addr", pf_pmem_address, 32'h0000_0820);
    @(negedge clk);
    prefetch_start = 1'b1;
    cacheline_address = 32'h0000_0900;
    cache_way = 1'b0;
    pf_pmem_resp = 1'b1;
    pf_pmem_rdata = D5;
    @(negedge clk);
    prefetch_start = 1'b0;
    pf_pmem_resp = 1'b0;
    chk("sc_discard_ready", prefetch_ready, 0);
    chk("sc_gap_read", pf_pmem_read, 0);
    @(negedge clk);
    chk("sc_reissue_addr", pf_pmem_address, 32'h0000_0920);
    resp(D6);
    chk("sc_rdata", prefetch_rdata, D6);
    chk("sc_cline", pf_cline_address, 32'h0000_0920);
    start(32'h0000_3000, 1'b1);
    chk("s6_read", pf_pmem_read, 1);
    #2 rst = 1'b0;
    #1 zero_chk("s6_async");
    @(negedge clk) rst = 1'b1;
    start(32'hFFFF_FFE4, 1'b1);
    seen = pf_pmem_read;
    repeat (3) begin
      @(negedge clk);
      seen |= pf_pmem_read;
    end
    chk("s5i_no_read", seen, 0);
    zero_chk("s5i");
    start(32'h0000_1044, 1'b1);
    chk("s6_fresh_read", pf_pmem_read, 1);
    chk("s6_fresh_addr", pf_pmem_address, 32'h0000_1060);
    resp(D1);
    chk("s6_fresh_ready", prefetch_ready, 1);
    chk("s6_fresh_rdata", prefetch_rdata, D1);
    chk("s6_fresh_cline", pf_cline_address, 32'h0000_1060);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
